// File: rtl/rv32i_pkg.sv
// Shared types and constants for the rv32i memory arbiter.
// Holds the boot FSM encoding, requester IDs and release length.
package rv32i_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LD = 2'd0,
        IF = 2'd1,
        DM = 2'd2
    } req_id_t;

    localparam int unsigned RELEASE_CYCLES = 2;

endpackage

// File: rtl/rv32i_rr_arb2.sv
// Two-way round-robin arbiter with a registered preference pointer.
// Requester 0 is fetch, requester 1 is data.
module rv32i_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 0: requester 0 preferred, 1: requester 1 preferred
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || !ptr)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (gnt[0]) begin
            ptr <= 1'b1;
        end else if (gnt[1]) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Shares one synchronous single-port memory between loader, fetch
// and load/store ports, and sequences the core out of boot.
module rv32i_mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              RN,
    input  logic              boot_en,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_rst
);

    localparam logic [1:0] REL_LAST = 2'(RELEASE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] rel_cnt, rel_nxt;
    logic       arb_en;
    logic [1:0] arb_gnt;
    req_id_t    gnt_id;
    logic       pend_if, pend_dm;

    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            state   <= BOOT;
            rel_cnt <= 2'd0;
        end else begin
            state   <= state_nxt;
            rel_cnt <= rel_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rel_nxt   = rel_cnt;
        if (boot_en) begin
            state_nxt = BOOT;
            rel_nxt   = 2'd0;
        end else begin
            unique case (state)
                BOOT: begin
                    state_nxt = RELEASE;
                    rel_nxt   = 2'd0;
                end
                RELEASE: begin
                    if (rel_cnt == REL_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        rel_nxt = rel_cnt + 2'd1;
                    end
                end
                RUN:     state_nxt = RUN;
                default: state_nxt = BOOT;
            endcase
        end
    end

    assign core_rst = (state != RUN);

    // Loader always wins; fetch/data only contend in RUN.
    assign ld_gnt = ld_req && !RN;
    assign arb_en = (state == RUN) && !ld_req && !RN;

    rv32i_rr_arb2 u_rr (
        .clk (clk),
        .rst (RN),
        .en  (arb_en),
        .req ({dm_req, if_req}),
        .gnt (arb_gnt)
    );

    assign if_gnt = arb_gnt[0];
    assign dm_gnt = arb_gnt[1];
    assign mem_en = ld_gnt || if_gnt || dm_gnt;

    always_comb begin
        gnt_id = LD;
        if (if_gnt) gnt_id = IF;
        if (dm_gnt) gnt_id = DM;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_en) begin
            unique case (gnt_id)
                LD: begin
                    mem_we    = ld_we;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_wdata;
                end
                IF: mem_addr = if_addr;
                DM: begin
                    mem_we    = dm_we;
                    mem_addr  = dm_addr;
                    mem_wdata = dm_wdata;
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    // Read returns are tracked independently of the FSM state.
    always_ff @(posedge clk or posedge RN) begin
        if (RN) begin
            pend_if <= 1'b0;
            pend_dm <= 1'b0;
        end else begin
            pend_if <= if_gnt;
            pend_dm <= dm_gnt && !dm_we;
        end
    end

    assign if_rvalid = pend_if;
    assign dm_rvalid = pend_dm;
    assign rd_data   = (pend_if || pend_dm) ? mem_rdata : '0;

endmodule
